// File: rtl/seq_acc.sv
`default_nettype none
// ============================================================================
//  Module   : seq_acc
//  Purpose  : Frame accumulator placed downstream of the sequence generator.
//             Sums the data of every first..last frame and emits one
//             single-beat result (sum, beat count) per frame, honouring
//             downstream backpressure/abort and passing both upstream.
//  Options  : SEQ_ACC_SAT_EN - when defined, the frame sum saturates at
//             2^AW-1 instead of wrapping modulo 2^AW.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_acc #(
  parameter int W  = 32,  // input data width
  parameter int AW = 40,  // accumulator / sum width (AW >= W)
  parameter int CW = 16   // beat-counter width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  uc_d0,
  input  logic [3:0]    uc_mflags,  // {again, first, last, vld}
  output logic [1:0]    cu_sflags,  // {abt, bsy}
  output logic [AW-1:0] cd_d0,
  output logic [CW-1:0] cd_d1,
  output logic [3:0]    cd_mflags,  // {again, first, last, vld}
  input  logic [1:0]    dc_sflags   // {abt, bsy}
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [AW-1:0] res_sum;
  logic [CW-1:0] res_cnt;
  logic          again_q;

  // Flag decode
  logic uc_vld, uc_first, uc_last;
  logic dc_bsy, dc_abt;
  logic cu_bsy;
  logic consume;
  logic out_vld;
  logic unused_uc_again;

  assign uc_vld          = uc_mflags[0];
  assign uc_last         = uc_mflags[1];
  assign uc_first        = uc_mflags[2];
  assign unused_uc_again = uc_mflags[3];  // informational only
  assign dc_bsy          = dc_sflags[0];
  assign dc_abt          = dc_sflags[1];

  assign out_vld = (state == ST_OUT);
  // Upstream only stalls while a result sits unaccepted downstream.
  assign cu_bsy  = out_vld & dc_bsy;
  assign consume = uc_vld & ~cu_bsy;

  assign cu_sflags = {dc_abt, cu_bsy};
  assign cd_mflags = {again_q, out_vld, out_vld, out_vld};
  assign cd_d0     = res_sum;
  assign cd_d1     = res_cnt;

  // Data zero-extended to accumulator width
  logic [AW-1:0] d_ext;
  assign d_ext = AW'(uc_d0);

  // Next accumulator value for a continuing beat
  logic [AW-1:0] acc_plus;
`ifdef SEQ_ACC_SAT_EN
  logic [AW:0] acc_wide;
  assign acc_wide = {1'b0, acc} + {1'b0, d_ext};
  // Once all-ones, any further add overflows (or adds 0), so it sticks.
  assign acc_plus = acc_wide[AW] ? {AW{1'b1}} : acc_wide[AW-1:0];
`else
  assign acc_plus = acc + d_ext;
`endif

  // Saturating beat count for a continuing beat
  logic [CW-1:0] cnt_plus;
  assign cnt_plus = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  // Frame FSM: accumulation, result capture, handshake and abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      res_sum <= '0;
      res_cnt <= '0;
      again_q <= 1'b0;
    end else begin
      again_q <= out_vld & dc_bsy;
      if (dc_abt) begin
        state <= ST_IDLE;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_OUT: begin
            // A held result blocks everything; otherwise behave as idle.
            if (!(out_vld && dc_bsy)) begin
              state <= ST_IDLE;
              if (consume && uc_first) begin
                if (uc_last) begin
                  res_sum <= d_ext;
                  res_cnt <= CW'(1);
                  state   <= ST_OUT;
                end else begin
                  acc   <= d_ext;
                  cnt   <= CW'(1);
                  state <= ST_ACC;
                end
              end
            end
          end
          ST_ACC: begin
            if (consume) begin
              if (uc_first) begin
                // Restart: partial frame is discarded
                if (uc_last) begin
                  res_sum <= d_ext;
                  res_cnt <= CW'(1);
                  state   <= ST_OUT;
                end else begin
                  acc <= d_ext;
                  cnt <= CW'(1);
                end
              end else if (uc_last) begin
                res_sum <= acc_plus;
                res_cnt <= cnt_plus;
                state   <= ST_OUT;
              end else begin
                acc <= acc_plus;
                cnt <= cnt_plus;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/seq_acc.md
Name: seq_acc

Overview:
- Stream consumer placed directly downstream of the sequence generator.
- Accepts framed beats (first..last) on the standard 4-bit master / 2-bit slave flag stream interface and accumulates data over each frame.
- Emits one single-beat result frame per input frame, carrying the sum and the beat count.
- Honours downstream backpressure and abort, and propagates both upstream.

Parameters:
- W, 32, input data width.
- AW, 40, accumulator/sum output width (AW >= W); sum is zero-extended from W.
- CW, 16, beat-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- uc_d0  in  W  upstream data.
- uc_mflags  in  4  upstream master flags {again, first, last, vld}.
- cu_sflags  out  2  slave flags to upstream {abt, bsy}.
- cd_d0  out  AW  frame sum.
- cd_d1  out  CW  frame beat count.
- cd_mflags  out  4  downstream master flags {again, first, last, vld}.
- dc_sflags  in  2  downstream slave flags {abt, bsy}.

Interface decision (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Beat transfer: an upstream beat is consumed in a cycle where uc_vld=1 and cu_bsy=0. uc_again is informational only and is ignored.
- Upstream flags:
  - cu_bsy = (state==ST_OUT) & dc_bsy.
  - cu_abt = dc_abt.
- State machine, registers state, acc[AW], cnt[CW], res_sum, res_cnt:
  - ST_IDLE (no frame open):
    - Consumed beat with first=1, last=0: acc=d, cnt=1, go to ST_ACC.
    - Consumed beat with first=1, last=1: res_sum=d, res_cnt=1, go to ST_OUT.
    - Consumed beat with first=0: dropped, stay in ST_IDLE.
  - ST_ACC (frame open):
    - Consumed beat with first=1: restarts the frame (acc=d, cnt=1); the partial frame is discarded. If last=1 too, go to ST_OUT with that single beat.
    - Consumed beat with last=1, first=0: res_sum=acc+d, res_cnt=cnt+1, go to ST_OUT.
    - Other consumed beats: acc+=d, cnt+=1.
  - ST_OUT (result held):
    - cd_vld=cd_first=cd_last=1, cd_d0=res_sum, cd_d1=res_cnt.
    - When dc_bsy=0 the result is transferred. An upstream beat may be consumed in the same cycle and follows the ST_IDLE rules.
    - Otherwise the result is held stable.
- Outputs in all other states: cd_vld=cd_first=cd_last=0. cd_d0/cd_d1 show the last result (don't-care, but stable).
- cd_again is registered: set next cycle iff cd_vld & dc_bsy, otherwise cleared.
- Latency: result valid in the cycle after the last beat is consumed.
- Throughput: one result per frame; no upstream stall unless a result is held under dc_bsy.
- Arithmetic:
  - Sum wraps modulo 2^AW.
  - cnt saturates at 2^CW-1.
- Abort: dc_abt=1 in any state takes priority over everything else. Next state is ST_IDLE, acc and cnt are cleared, and any held result is dropped. The upstream beat in that cycle is not consumed into a frame.
- Reset values:
  - state=ST_IDLE; acc, cnt, res_sum, res_cnt all 0.
  - cd_mflags=0, cd_d0=0, cd_d1=0, cu_sflags=0 (with dc_sflags=0).
- Reset asserted mid-frame or mid-output: everything returns to the reset values immediately (asynchronously).

Optional Feature:
- Macro: SEQ_ACC_SAT_EN.
- Defined: the sum saturates at 2^AW-1 instead of wrapping. Once saturated it stays saturated for the rest of that frame.
- Undefined: modulo-2^AW wrap, with no saturation logic present.

Test Plan:
- Frame 0,4,8,12 (first on 0, last on 12), dc_sflags=0 -> one cycle later cd_vld=first=last=1, cd_d0=24, cd_d1=4; cd_vld=0 the following cycle.
- Same frame with dc_bsy=1 for 3 cycles once the result is out:
  - cd_d0=24 held for all 4 cycles.
  - cd_again=1 in cycles 2-4.
  - cu_bsy=1 for 3 cycles; the upstream beat is not consumed until dc_bsy=0.
- Single beat first=last=1, d=7 -> next cycle cd_d0=7, cd_d1=1. A back-to-back frame of 3,5 is accepted in the cycle the result transfers -> sum 8, count 2.
- Restart: 5(first), 6, 10(first), 1(last) -> cd_d0=11, cd_d1=2. Also: a beat 9 with first=0 while in ST_IDLE produces no output.
- Abort: frame 1,2 open, dc_abt=1 for 1 cycle -> cu_abt=1 that cycle, no result emitted. The next frame 4(first),4(last) -> cd_d0=8, cd_d1=2.
- Wrap check with W=8, AW=8: frame 200,100:
  - Without SEQ_ACC_SAT_EN -> cd_d0=44.
  - With SEQ_ACC_SAT_EN -> cd_d0=255.
  - Asserting rst_n low mid-frame clears all outputs to 0.
